// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM round-robin arbiter.
package ram_arb_pkg;

    localparam int RAM_WIDTH_DEF = 8;
    localparam int ADDR_SIZE_DEF = 10;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam int ID_W = 1;
    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_BURST = ST_BURST
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on contention the requester that
// did not win last time is chosen; the grant vector is one-hot or zero.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_winner_i,
    output logic [1:0] gnt_o
);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_winner_i == req_id_t'(1)) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter in front of a single-port synchronous RAM, with optional
// locked bursts and routing of read data back to the issuing requester.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RAM_WIDTH = RAM_WIDTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_0,
    input  logic                 req_1,
    input  logic                 we_0,
    input  logic                 we_1,
    input  logic                 lock_0,
    input  logic                 lock_1,
    input  logic [ADDR_SIZE-1:0] addr_0,
    input  logic [ADDR_SIZE-1:0] addr_1,
    input  logic [RAM_WIDTH-1:0] wdata_0,
    input  logic [RAM_WIDTH-1:0] wdata_1,
    output logic                 gnt_0,
    output logic                 gnt_1,
    output logic                 rvalid_0,
    output logic                 rvalid_1,
    output logic [RAM_WIDTH-1:0] rdata,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_wr_add,
    output logic [ADDR_SIZE-1:0] ram_rd_add,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W:0]  MAX_CNT = (CNT_W + 1)'(MAX_BURST);
    localparam bit              LOCK_EN = (MAX_BURST > 1);

    arb_state_e             state_q, state_d;
    req_id_t                owner_q, owner_d;
    req_id_t                last_winner_q, last_winner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W:0]         cnt_inc;
    logic                   rd_pend_q;
    req_id_t                rd_id_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [RAM_WIDTH-1:0]   wdata_q;

    logic [1:0]             req, pick, gnt;
    logic                   xfer;
    req_id_t                xfer_id;
    logic                   sel_we, sel_lock;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [RAM_WIDTH-1:0]   sel_wdata;

    assign req = {req_1, req_0};

    rr_pick2 u_pick (
        .req_i         (req),
        .last_winner_i (last_winner_q),
        .gnt_o         (pick)
    );

    // During a burst only the owner can be granted; reset masks every grant.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (state_q == S_BURST) begin
                gnt[owner_q] = req[owner_q];
            end else begin
                gnt = pick;
            end
        end
    end

    assign xfer      = |gnt;
    assign xfer_id   = req_id_t'(gnt[1]);
    assign sel_we    = gnt[1] ? we_1    : we_0;
    assign sel_lock  = gnt[1] ? lock_1  : lock_0;
    assign sel_addr  = gnt[1] ? addr_1  : addr_0;
    assign sel_wdata = gnt[1] ? wdata_1 : wdata_0;

    assign gnt_0       = gnt[0];
    assign gnt_1       = gnt[1];
    assign ram_wr_en   = xfer & sel_we;
    assign ram_rd_en   = xfer & ~sel_we;
    assign ram_wr_add  = xfer ? sel_addr  : addr_q;
    assign ram_rd_add  = xfer ? sel_addr  : addr_q;
    assign ram_data_in = xfer ? sel_wdata : wdata_q;

    assign rvalid_0 = rd_pend_q & (rd_id_q == req_id_t'(0));
    assign rvalid_1 = rd_pend_q & (rd_id_q == req_id_t'(1));
    assign rdata    = ram_data_out;

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        last_winner_d = xfer ? xfer_id : last_winner_q;
        case (state_q)
            S_IDLE: begin
                if (xfer && LOCK_EN && sel_lock) begin
                    state_d = S_BURST;
                    owner_d = xfer_id;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_BURST: begin
                // Dropping req, dropping lock or reaching MAX_BURST all end the burst.
                if (xfer && sel_lock && (cnt_inc < MAX_CNT)) begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= '0;
            last_winner_q <= req_id_t'(1);
            cnt_q         <= '0;
            rd_pend_q     <= 1'b0;
            rd_id_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            cnt_q         <= cnt_d;
            rd_pend_q     <= ram_rd_en;
            rd_id_q       <= xfer_id;
            if (xfer) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

endmodule
